// File: rtl/bounce_shifter.sv
// bounce_shifter: parametrised one-hot shift-pattern generator.
// A single '1' travels across an N-bit register. It can bounce between the
// two ends, rotate right, rotate left, or stay frozen. A prescaler sets how
// often it steps. Each end raises a one-cycle terminal-count pulse, and a
// wrapping counter counts completed periods.
//
// Ports:
//   clk           rising-edge clock
//   rstna         asynchronous active-low reset
//   clr           synchronous clear to the reset state (highest priority)
//   ena           count enable; when low, prescaler, Q and dir hold
//   mode[1:0]     00 bounce, 01 rotate right, 10 rotate left, 11 freeze
//   div[DIV_W]    step once every div+1 enabled cycles
//   Q[N]          registered one-hot pattern
//   dir           1 = moving right (toward bit 0), 0 = moving left
//   tc_lsb        one-cycle pulse when the '1' arrives at bit 0
//   tc_msb        one-cycle pulse when the '1' arrives at bit N-1
//   period_count  completed periods, wraps modulo 2^CNT_W
module bounce_shifter #(
    parameter int unsigned N     = 8,
    parameter int unsigned DIV_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstna,
    input  logic             clr,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [N-1:0]     Q,
    output logic             dir,
    output logic             tc_lsb,
    output logic             tc_msb,
    output logic [CNT_W-1:0] period_count
);

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_ROT_R  = 2'b01;
    localparam logic [1:0] MODE_ROT_L  = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    localparam logic [N-1:0] Q_RST = {1'b1, {(N-1){1'b0}}};

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [N-1:0]     q_q, q_d;
    logic             dir_q, dir_d;
    logic             tc_lsb_q, tc_lsb_d;
    logic             tc_msb_q, tc_msb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_c;
    logic             step_c;
    logic             period_done_c;

    // Prescaler, pattern movement, terminal counts and period counting
    always_comb begin
        presc_d       = presc_q;
        q_d           = q_q;
        dir_d         = dir_q;
        cnt_d         = cnt_q;
        active_c      = ena && (mode != MODE_FREEZE);
        step_c        = active_c && (presc_q == div);
        period_done_c = 1'b0;

        // A div lowered below presc fails the compare until presc wraps
        if (active_c) begin
            presc_d = step_c ? '0 : presc_q + DIV_W'(1);
        end

        if (step_c) begin
            case (mode)
                MODE_BOUNCE: begin
                    // Reverse and move in the same step so no end dwell
                    if (dir_q) begin
                        if (q_q[0]) begin
                            dir_d = 1'b0;
                            q_d   = q_q << 1;
                        end else begin
                            q_d = q_q >> 1;
                        end
                    end else begin
                        if (q_q[N-1]) begin
                            dir_d = 1'b1;
                            q_d   = q_q >> 1;
                        end else begin
                            q_d = q_q << 1;
                        end
                    end
                end
                MODE_ROT_R: begin
                    dir_d = 1'b1;
                    q_d   = {q_q[0], q_q[N-1:1]};
                end
                MODE_ROT_L: begin
                    dir_d = 1'b0;
                    q_d   = {q_q[N-2:0], q_q[N-1]};
                end
                default: ;
            endcase
        end

        tc_lsb_d = step_c && q_d[0];
        tc_msb_d = step_c && q_d[N-1];

        // A period ends at the LSB, except in rotate-left where it ends at the MSB
        period_done_c = (mode == MODE_ROT_L) ? tc_msb_d : tc_lsb_d;
        if (period_done_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; clr overrides any step in the same cycle
    always_ff @(posedge clk or negedge rstna) begin
        if (!rstna) begin
            presc_q  <= '0;
            q_q      <= Q_RST;
            dir_q    <= 1'b1;
            tc_lsb_q <= 1'b0;
            tc_msb_q <= 1'b0;
            cnt_q    <= '0;
        end else if (clr) begin
            presc_q  <= '0;
            q_q      <= Q_RST;
            dir_q    <= 1'b1;
            tc_lsb_q <= 1'b0;
            tc_msb_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            presc_q  <= presc_d;
            q_q      <= q_d;
            dir_q    <= dir_d;
            tc_lsb_q <= tc_lsb_d;
            tc_msb_q <= tc_msb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Q            = q_q;
    assign dir          = dir_q;
    assign tc_lsb       = tc_lsb_q;
    assign tc_msb       = tc_msb_q;
    assign period_count = cnt_q;

endmodule

// File: tb/tb_bounce_shifter.sv
// Testbench for bounce_shifter. The stimulus process drives inputs on the
// falling edge. For every cycle it steps a position-based reference model and
// queues the output it expects after the next rising edge. A separate monitor
// pops from that queue after each rising edge and compares.
module tb_bounce_shifter;

    localparam int N     = 8;
    localparam int DIV_W = 4;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [N-1:0]     q;
        logic             dir;
        logic             tl;
        logic             tm;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rstna;
    logic             clr;
    logic             ena;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     Q;
    logic             dir;
    logic             tc_lsb;
    logic             tc_msb;
    logic [CNT_W-1:0] period_count;

    bounce_shifter #(.N(N), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstna        (rstna),
        .clr          (clr),
        .ena          (ena),
        .mode         (mode),
        .div          (div),
        .Q            (Q),
        .dir          (dir),
        .tc_lsb       (tc_lsb),
        .tc_msb       (tc_msb),
        .period_count (period_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference model state: index of the '1', direction, prescaler, periods
    int m_pos;
    bit m_dir;
    int m_presc;
    int m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.q   = N'(1) << (N - 1);
        e.dir = 1'b1;
        e.tl  = 1'b0;
        e.tm  = 1'b0;
        e.cnt = '0;
        return e;
    endfunction

    task automatic model_reset();
        m_pos   = N - 1;
        m_dir   = 1'b1;
        m_presc = 0;
        m_cnt   = 0;
    endtask

    task automatic check_reset_now(input string tag);
        exp_t e;
        e = reset_exp();
        check({tag, "_q"}, 64'(Q), 64'(e.q));
        check({tag, "_dir"}, 64'(dir), 64'(e.dir));
        check({tag, "_tc_lsb"}, 64'(tc_lsb), 64'(0));
        check({tag, "_tc_msb"}, 64'(tc_msb), 64'(0));
        check({tag, "_cnt"}, 64'(period_count), 64'(0));
    endtask

    // Apply one cycle of inputs and queue the expected post-edge outputs
    task automatic drive(input bit c, input bit en, input logic [1:0] md, input int dv);
        exp_t e;
        bit   stepped;
        bit   done;
        clr  = c;
        ena  = en;
        mode = md;
        div  = DIV_W'(dv);
        if (c) begin
            model_reset();
            e = reset_exp();
        end else begin
            stepped = 1'b0;
            if (en && md != 2'd3) begin
                if (m_presc == dv) begin
                    stepped = 1'b1;
                    m_presc = 0;
                end else begin
                    m_presc = (m_presc + 1) % (1 << DIV_W);
                end
            end
            if (stepped) begin
                case (md)
                    2'd0: begin
                        if (m_dir) begin
                            if (m_pos == 0) begin m_dir = 1'b0; m_pos = 1; end
                            else m_pos = m_pos - 1;
                        end else begin
                            if (m_pos == N - 1) begin m_dir = 1'b1; m_pos = N - 2; end
                            else m_pos = m_pos + 1;
                        end
                    end
                    2'd1: begin m_dir = 1'b1; m_pos = (m_pos + N - 1) % N; end
                    default: begin m_dir = 1'b0; m_pos = (m_pos + 1) % N; end
                endcase
            end
            e.q   = N'(1) << m_pos;
            e.dir = m_dir;
            e.tl  = stepped && (m_pos == 0);
            e.tm  = stepped && (m_pos == N - 1);
            done  = (md == 2'd2) ? e.tm : e.tl;
            if (done) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            e.cnt = CNT_W'(m_cnt);
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare each queued expectation against the settled outputs
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rstna && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("q", 64'(Q), 64'(e.q));
                check("dir", 64'(dir), 64'(e.dir));
                check("tc_lsb", 64'(tc_lsb), 64'(e.tl));
                check("tc_msb", 64'(tc_msb), 64'(e.tm));
                check("period_count", 64'(period_count), 64'(e.cnt));
            end
        end
    end

    int cur_div;

    initial begin
        rstna = 1'b0;
        clr   = 1'b0;
        ena   = 1'b0;
        mode  = 2'd0;
        div   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_now("reset");
        rstna = 1'b1;

        // Bounce at full rate through more than two periods
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 2'd0, 0);

        // Prescaler div=2 with a 5-cycle enable gap mid-count
        drive(1'b1, 1'b1, 2'd0, 2);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 2'd0, 2);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 2'd0, 2);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 2'd0, 2);

        // Rotate right to 0x04, then switch to bounce: 0x02, 0x01, 0x02
        drive(1'b1, 1'b0, 2'd0, 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 2'd1, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2'd0, 0);

        // Rotate right through the wrap, rotate left through both wraps
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 2'd1, 0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 2'd2, 0);

        // Freeze for 20 cycles, then clr coincident with a step
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 2'd3, 0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 2'd0, 0);
        drive(1'b1, 1'b1, 2'd0, 0);
        drive(1'b0, 1'b1, 2'd0, 0);

        // Long bounce run so period_count wraps past 2^CNT_W
        for (int i = 0; i < 3700; i++) drive(1'b0, 1'b1, 2'd0, 0);

        // Asynchronous reset between edges
        #2;
        rstna = 1'b0;
        #1;
        check_reset_now("async_reset");
        @(negedge clk);
        rstna = 1'b1;
        model_reset();

        // Randomised mix of modes, enables, divisors and clears
        cur_div = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0)
                cur_div = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 8),
                  2'($urandom_range(0, 3)), cur_div);
        end

        @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bounce_shifter.md
# bounce_shifter

Parametrised one-hot shift-pattern generator and successor to our fixed 8-bit bouncing shift register. A single '1' travels across an N-bit register in one of three run modes: bounce, rotate-right or rotate-left. The register can also be frozen. A programmable prescaler sets the step rate, both ends raise terminal-count pulses, and a wrapping period counter tracks completed periods. It drives LED/scan patterns and acts as a slow sequencing tick source.

## Interface
- N, 8, register width; legal range N >= 2
- DIV_W, 4, prescaler divide-value width
- CNT_W, 8, period counter width
- clk  in  1  clock, rising edge
- rstna  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear to reset state; priority over all other inputs
- ena  in  1  count enable; when 0, prescaler, Q and dir hold
- mode  in  2  00 bounce, 01 rotate right, 10 rotate left, 11 freeze
- div  in  DIV_W  step every div+1 enabled cycles
- Q  out  N  one-hot pattern, registered
- dir  out  1  current direction: 1 = right (toward bit 0), 0 = left
- tc_lsb  out  1  one-cycle pulse when the '1' arrives at bit 0
- tc_msb  out  1  one-cycle pulse when the '1' arrives at bit N-1
- period_count  out  CNT_W  completed periods, wraps modulo 2^CNT_W

## Operation
- Reset state (rstna=0 async, or clr=1 at an edge):
  - Q = 1<<(N-1)
  - dir = 1
  - tc_lsb = tc_msb = 0
  - period_count = 0
  - prescaler = 0
- Prescaler, DIV_W bits:
  - Active when ena=1 and mode != 11.
  - If presc == div: step=1 and presc <= 0. Otherwise presc <= presc+1.
  - When ena=0 or mode=11, presc holds and step=0.
  - A change to div takes effect on the next comparison. If presc > div, the comparison fails until presc wraps through 0.
- Bounce (mode 00), on step:
  - dir=1, Q[0]=0: Q <= Q>>1.
  - dir=1, Q[0]=1: dir <= 0, Q <= Q<<1. The reversal and the move happen in the same step, so the '1' never dwells at an end.
  - dir=0, Q[N-1]=0: Q <= Q<<1.
  - dir=0, Q[N-1]=1: dir <= 1, Q <= Q>>1.
  - One period is 2(N-1) steps.
- Rotate right (mode 01): on step, dir <= 1 and Q <= {Q[0], Q[N-1:1]}.
- Rotate left (mode 10): on step, dir <= 0 and Q <= {Q[N-2:0], Q[N-1]}.
- Freeze (mode 11): Q, dir, presc and period_count hold; tc outputs return to 0.
- Terminal counts (registered, derived from the next Q):
  - tc_lsb <= step & nextQ[0]
  - tc_msb <= step & nextQ[N-1]
  - Each is high for exactly one clk, even if ena drops in that cycle.
- period_count increments, and wraps, at the same edge as:
  - the tc_lsb assertion in modes 00 and 01;
  - the tc_msb assertion in mode 10.
- Mode changes are sampled per cycle. Entering bounce keeps the current dir and Q, and bounce rules apply at the next step.
- Q stays one-hot in every mode. No state can yield Q = 0.

## Timing
- Q, dir, tc_* and period_count all update on the same rising edge as the step.
- Latency: with ena held high from reset release, the first step occurs at the (div+1)-th rising edge.
- div=0 steps on every enabled cycle.
- Simultaneous clr and step: clr wins. The outputs take the reset state and no tc pulse is generated.
- Async reset mid-step: outputs take reset values immediately, with no clock required. Operation restarts from presc=0 after release.
- At the N=2 boundary, bounce and rotate-right produce identical Q sequences.

## Test plan
- Reset/bounce, N=8, div=0, mode=00, ena=1:
  - Q runs 0x80,0x40,…,0x01,0x02,…,0x80.
  - tc_lsb is high only in the cycle Q=0x01, and period_count becomes 1 then.
  - tc_msb is high in the cycle Q returns to 0x80, 14 steps after reset.
- Prescaler, div=2:
  - Q changes every 3rd edge.
  - Dropping ena for 5 cycles mid-count delays the next step by exactly 5 cycles.
- Rotate, N=8:
  - mode=01 starting from Q=0x01 gives Q=0x80 next step, with tc_msb=1 and dir=1.
  - mode=10 from Q=0x80 gives Q=0x01, with tc_lsb=1 and period_count unchanged.
  - Continuing mode=10, reaching Q=0x80 raises tc_msb and increments period_count.
- Freeze and mode switch:
  - mode=11 at Q=0x10 holds Q for 20 cycles, with no tc pulses.
  - Switching mode 01→00 at Q=0x04 continues 0x02, 0x01, 0x02.
- Clear and reset:
  - clr=1 coincident with a step gives Q=0x80, period_count=0, tc=0.
  - Asserting rstna low between edges forces the reset values asynchronously.
- Counter wrap, CNT_W=2, N=4: after 4 periods (24 steps), period_count returns to 0.
